// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and default link parameters
// used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DEFAULT_DATA_BITS    = 8;

  // Index width for a counter over n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Wrapping bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and
// flags the last clock of each bit period.
module uart_baud_cnt import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             bit_end
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == CNT_MAX);
  assign cnt     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// 8N1-style UART transmitter: accepts a word over valid/ready and shifts it
// out LSB-first framed by one start and one stop bit.
module uart_tx_core import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = idx_width(DATA_BITS);
  // tx_done is registered, so it is raised one count before the final one.
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     cnt;
  logic                 bit_end;
  logic                 accept;

  assign accept   = tx_valid & ready_q;
  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .en     (busy_q),
    .clr    (accept),
    .cnt    (cnt),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = tx_data;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and then registered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == STOP) && (cnt == DONE_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: a frame-position model predicts every
// output each cycle for a default instance and a small-parameter instance.
module tb_uart_tx_core;

  localparam int CPB  = 4;
  localparam int DB   = 8;
  localparam int CPB2 = 2;
  localparam int DB2  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DB-1:0]  tx_data;
  logic           tx_valid;
  logic           tx, tx_ready, tx_busy, tx_done;
  logic [DB2-1:0] tx_data2;
  logic           tx_valid2;
  logic           tx2, tx_ready2, tx_busy2, tx_done2;

  int compared   = 0;
  int mismatched = 0;

  uart_tx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_core #(.CLKS_PER_BIT(CPB2), .DATA_BITS(DB2)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is just a position counter t since accept.
  bit          m_busy = 1'b0, m2_busy = 1'b0;
  int          m_t = 0, m2_t = 0;
  logic [7:0]  m_data = '0, m2_data = '0;

  function automatic logic exp_line(input bit busy, input int t, input int cpb,
                                    input int db, input logic [7:0] d);
    int p;
    if (!busy) return 1'b1;
    p = t / cpb;
    if (p == 0) return 1'b0;
    if (p <= db) return d[p-1];
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 1'b0;
      m2_busy = 1'b0;
    end else begin
      if (!m_busy) begin
        if (tx_valid === 1'b1) begin
          m_busy = 1'b1; m_t = 0; m_data = tx_data;
        end
      end else begin
        m_t++;
        if (m_t == (DB + 2) * CPB) m_busy = 1'b0;
      end
      if (!m2_busy) begin
        if (tx_valid2 === 1'b1) begin
          m2_busy = 1'b1; m2_t = 0; m2_data = {3'b000, tx_data2};
        end
      end else begin
        m2_t++;
        if (m2_t == (DB2 + 2) * CPB2) m2_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("tx",    tx,       exp_line(m_busy, m_t, CPB, DB, m_data));
    checkOutput("ready", tx_ready, !m_busy);
    checkOutput("busy",  tx_busy,  m_busy);
    checkOutput("done",  tx_done,  m_busy && (m_t == (DB + 2) * CPB - 1));
    checkOutput("tx2",    tx2,       exp_line(m2_busy, m2_t, CPB2, DB2, m2_data));
    checkOutput("ready2", tx_ready2, !m2_busy);
    checkOutput("busy2",  tx_busy2,  m2_busy);
    checkOutput("done2",  tx_done2,  m2_busy && (m2_t == (DB2 + 2) * CPB2 - 1));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(input bit second);
    int n = 0;
    while (((second ? tx_ready2 : tx_ready) !== 1'b1) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL ready_timeout: got 0 expected 1 at %0t", $time);
    end
  endtask

  task automatic applyStimulus(input logic [DB-1:0] d);
    waitReady(1'b0);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] pat;
    logic [9:0] seen;
    logic [6:0] pat2;
    int done_c, start_c, c, busy_n;

    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_valid2 = 1'b0; tx_data2 = '0;
    repeat (3) tick();
    checkOutput("rst_tx",    tx,       1'b1);
    checkOutput("rst_ready", tx_ready, 1'b1);
    checkOutput("rst_busy",  tx_busy,  1'b0);
    checkOutput("rst_done",  tx_done,  1'b0);
    rst = 1'b0;
    tick();

    $display("[TB] single byte 0xA5");
    pat = 10'b1101001010;
    applyStimulus(8'hA5);
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      if (n < 40) checkOutput("a5_line", tx, pat[n/4]);
      checkOutput("a5_done",  tx_done,  n == 39);
      checkOutput("a5_ready", tx_ready, n == 40);
    end

    $display("[TB] back-to-back 0x00 then 0xFF");
    waitReady(1'b0);
    tx_data = 8'h00; tx_valid = 1'b1;
    tick();
    tx_data = 8'hFF;
    done_c = -1; start_c = -1; c = 0;
    while (start_c < 0 && c < 200) begin
      @(negedge clk);
      if (tx_done === 1'b1) done_c = c;
      else if (done_c >= 0 && tx === 1'b0) start_c = c;
      c++;
    end
    tx_valid = 1'b0;
    checkOutput("b2b_gap", start_c - done_c, 2);
    waitReady(1'b0);

    $display("[TB] ignored request mid-frame");
    applyStimulus(8'h5A);
    repeat (10) tick();
    tx_data = 8'h3C; tx_valid = 1'b1;
    repeat (3) tick();
    tx_valid = 1'b0;
    waitReady(1'b0);
    repeat (3) tick();

    $display("[TB] data stability 0x81");
    applyStimulus(8'h81);
    for (int n = 0; n < 40; n++) begin
      tx_data = 8'($urandom);
      @(negedge clk);
      if (n % 4 == 2) seen[n/4] = tx;
      @(posedge clk); #1;
    end
    checkOutput("stable_81", seen, 10'b1100000010);
    waitReady(1'b0);

    $display("[TB] async reset during data bit 3");
    applyStimulus(8'hC3);
    repeat (17) tick();
    #1 rst = 1'b1;
    #1;
    checkOutput("arst_tx",    tx,       1'b1);
    checkOutput("arst_busy",  tx_busy,  1'b0);
    checkOutput("arst_ready", tx_ready, 1'b1);
    checkOutput("arst_done",  tx_done,  1'b0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    applyStimulus(8'h96);
    waitReady(1'b0);

    $display("[TB] parameter corner 0x15");
    pat2 = 7'b1101010;
    waitReady(1'b1);
    tx_data2 = 5'h15; tx_valid2 = 1'b1;
    tick();
    tx_valid2 = 1'b0;
    busy_n = 0;
    for (int n = 0; n <= 14; n++) begin
      @(negedge clk);
      if (tx_busy2 === 1'b1) busy_n++;
      if (n < 14) checkOutput("corner_line", tx2, pat2[n/2]);
      checkOutput("corner_done", tx_done2, n == 13);
    end
    checkOutput("corner_len", busy_n, 14);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++) begin
      tx_valid  = ($urandom_range(0, 3) == 0);
      tx_data   = 8'($urandom);
      tx_valid2 = ($urandom_range(0, 2) == 0);
      tx_data2  = 5'($urandom);
      tick();
    end
    tx_valid = 1'b0; tx_valid2 = 1'b0;
    waitReady(1'b0);
    waitReady(1'b1);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
